// File: rtl/pingpong_pkg.sv
// Shared types and defaults for the ping-pong byte buffer.
package pingpong_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 4;

    // Counter width for a bank of the given depth (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    localparam int unsigned DefCntW = cnt_width(DefDepth);

    // Index of one of the two banks.
    typedef logic [0:0] bank_sel_t;

    // Word index within a bank of the default depth.
    typedef logic [DefCntW-1:0] cnt_t;

endpackage

// File: rtl/pingpong_if.sv
// Stream interface of the ping-pong buffer: input words in, block-released words out.
interface pingpong_if
    import pingpong_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) ();

    logic             valid;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;

    // Producer/consumer side: drives input words, observes the output stream.
    modport master (
        output valid,
        output data_in,
        input  data_out,
        input  out_valid
    );

    // Buffer side.
    modport slave (
        input  valid,
        input  data_in,
        output data_out,
        output out_valid
    );

endinterface

// File: rtl/pingpong_bank.sv
// One bank of the ping-pong buffer: DEPTH x WIDTH registers, synchronous write,
// combinational read. Contents are not reset; a bank is only read after it is filled.
module pingpong_bank
    import pingpong_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    localparam int unsigned CntW = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [CntW-1:0]  waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [CntW-1:0]  raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming word at the write address.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read; the top registers the result.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/pingpong.sv
// Two-bank ping-pong buffer. The writer fills one bank while the reader drains the
// other; a bank is released for reading only once all DEPTH words have arrived.
module pingpong
    import pingpong_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input logic        clk,
    input logic        reset,
    pingpong_if.slave  bus
);

    localparam int unsigned CntW = cnt_width(DEPTH);
    typedef logic [CntW-1:0] ptr_t;
    localparam ptr_t LastIdx = ptr_t'(DEPTH - 1);

    if (DEPTH < 2) begin : g_depth_check
        $error("pingpong: DEPTH must be at least 2");
    end

    // Write side.
    bank_sel_t wr_bank_q, wr_bank_d;
    ptr_t      wr_cnt_q, wr_cnt_d;

    // Read side.
    logic      rd_active_q, rd_active_d;
    ptr_t      rd_cnt_q, rd_cnt_d;

    // Output register.
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;

    logic             wr_last;
    logic             rd_last;
    logic [1:0]       bank_we;
    logic [WIDTH-1:0] bank_rdata [2];
    logic [WIDTH-1:0] rd_data;

    assign wr_last = bus.valid && (wr_cnt_q == LastIdx);
    assign rd_last = rd_active_q && (rd_cnt_q == LastIdx);

    // The reader always drains the bank the writer is not filling.
    assign rd_data = (wr_bank_q == bank_sel_t'(0)) ? bank_rdata[1] : bank_rdata[0];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = bus.valid && (wr_bank_q == bank_sel_t'(b));

        pingpong_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_bank (
            .clk_i   (clk),
            .we_i    (bank_we[b]),
            .waddr_i (wr_cnt_q),
            .wdata_i (bus.data_in),
            .raddr_i (rd_cnt_q),
            .rdata_o (bank_rdata[b])
        );
    end

    // Next-state: advance the fill position and swap banks on the last word of a block.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (bus.valid) begin
            if (wr_last) begin
                wr_cnt_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + ptr_t'(1);
            end
        end
    end

    // Next-state: drain the full bank one word per cycle into the output register.
    always_comb begin
        rd_active_d = rd_active_q;
        rd_cnt_d    = rd_cnt_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        if (rd_active_q) begin
            data_out_d  = rd_data;
            out_valid_d = 1'b1;
            if (rd_last) begin
                rd_cnt_d    = '0;
                rd_active_d = 1'b0;
            end else begin
                rd_cnt_d = rd_cnt_q + ptr_t'(1);
            end
        end
        // A completed fill starts the next drain, even if the previous drain ends this edge.
        if (wr_last) begin
            rd_active_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q   <= '0;
            wr_cnt_q    <= '0;
            rd_active_q <= 1'b0;
            rd_cnt_q    <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_active_q <= rd_active_d;
            rd_cnt_q    <= rd_cnt_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_pingpong.sv
// Self-checking bench for the ping-pong buffer: directed scenarios plus random traffic
// checked against a queue-based model of the block-release behaviour.
module tb_pingpong;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic reset;

    pingpong_if #(.WIDTH(WIDTH)) bus ();

    pingpong #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: words collect into a partial block; a complete block is queued
    // for output and leaves one word per edge, starting the edge after it completed.
    logic [WIDTH-1:0] partial_q [$];
    logic [WIDTH-1:0] out_q [$];
    logic [WIDTH-1:0] exp_data;
    logic             exp_valid;

    task automatic model_reset();
        partial_q.delete();
        out_q.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [WIDTH-1:0] d);
        exp_valid = 1'b0;
        if (out_q.size() > 0) begin
            exp_data  = out_q.pop_front();
            exp_valid = 1'b1;
        end
        if (v) begin
            partial_q.push_back(d);
            if (partial_q.size() == DEPTH) begin
                foreach (partial_q[i]) out_q.push_back(partial_q[i]);
                partial_q.delete();
            end
        end
    endtask

    // Drive one cycle of input, advance the model across the edge, settle after the edge.
    task automatic drive_edge(input logic v, input logic [WIDTH-1:0] d);
        bus.valid   = v;
        bus.data_in = d;
        @(posedge clk);
        model_edge(v, d);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.valid = 1'b0;
        bus.data_in = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.data_out !== '0)
                $display("FAIL reset_hold cyc %0d: out_valid=%b data_out=%0d, want 0/0",
                         i, bus.out_valid, bus.data_out);
            else passes++;
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 8'hA5);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.data_out !== '0)
                $display("FAIL reset_idle cyc %0d: out_valid=%b data_out=%0d, want 0/0",
                         i, bus.out_valid, bus.data_out);
            else passes++;
        end
    endtask

    task automatic test_first_block();
        logic [WIDTH-1:0] got [$];
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive_edge(1'b1, 8'(i + 1));
            else drive_edge(1'b0, '0);
            if (bus.out_valid === 1'b1) got.push_back(bus.data_out);
            checks++;
            if (bus.out_valid !== exp_valid || bus.data_out !== exp_data)
                $display("FAIL first_block edge %0d: out_valid=%b data_out=%0d, want %b/%0d",
                         i + 1, bus.out_valid, bus.data_out, exp_valid, exp_data);
            else passes++;
        end
        checks++;
        if (got.size() != 4 || got[0] !== 8'd1 || got[1] !== 8'd2 || got[2] !== 8'd3 ||
            got[3] !== 8'd4)
            $display("FAIL first_block_seq: got %0d words %p, want 1,2,3,4", got.size(), got);
        else passes++;
    endtask

    task automatic test_gap();
        logic [WIDTH-1:0] got [$];
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 8'hFF);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.data_out !== 8'd4)
                $display("FAIL gap_idle cyc %0d: out_valid=%b data_out=%0d, want 0/4",
                         i, bus.out_valid, bus.data_out);
            else passes++;
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 2) drive_edge(1'b1, 8'(i + 7));
            else drive_edge(1'b0, '0);
            if (bus.out_valid === 1'b1) got.push_back(bus.data_out);
            checks++;
            if (bus.out_valid !== exp_valid || bus.data_out !== exp_data)
                $display("FAIL gap_drain edge %0d: out_valid=%b data_out=%0d, want %b/%0d",
                         i, bus.out_valid, bus.data_out, exp_valid, exp_data);
            else passes++;
        end
        checks++;
        if (got.size() != 4 || got[0] !== 8'd5 || got[1] !== 8'd6 || got[2] !== 8'd7 ||
            got[3] !== 8'd8)
            $display("FAIL gap_seq: got %0d words %p, want 5,6,7,8", got.size(), got);
        else passes++;
    endtask

    task automatic test_reset_mid();
        drive_edge(1'b1, 8'd9);
        drive_edge(1'b1, 8'd10);
        checks++;
        if (bus.data_out !== 8'd8 || bus.out_valid !== 1'b0)
            $display("FAIL pre_reset: out_valid=%b data_out=%0d, want 0/8",
                     bus.out_valid, bus.data_out);
        else passes++;
        bus.valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== '0 || bus.out_valid !== 1'b0)
            $display("FAIL async_reset: out_valid=%b data_out=%0d, want 0/0",
                     bus.out_valid, bus.data_out);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_after_reset();
        logic [WIDTH-1:0] got [$];
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive_edge(1'b1, 8'(i + 1));
            else drive_edge(1'b0, '0);
            if (bus.out_valid === 1'b1) got.push_back(bus.data_out);
            checks++;
            if (bus.out_valid !== exp_valid || bus.data_out !== exp_data)
                $display("FAIL after_reset edge %0d: out_valid=%b data_out=%0d, want %b/%0d",
                         i + 1, bus.out_valid, bus.data_out, exp_valid, exp_data);
            else passes++;
        end
        checks++;
        if (got.size() != 4 || got[0] !== 8'd1 || got[1] !== 8'd2 || got[2] !== 8'd3 ||
            got[3] !== 8'd4)
            $display("FAIL after_reset_seq: got %0d words %p, want 1,2,3,4", got.size(), got);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] got [$];
        int run;
        int max_run;
        bit seq_ok;
        run = 0;
        max_run = 0;
        apply_reset();
        for (int i = 0; i < 22; i++) begin
            if (i < 16) drive_edge(1'b1, 8'(i + 1));
            else drive_edge(1'b0, '0);
            if (bus.out_valid === 1'b1) begin
                got.push_back(bus.data_out);
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            checks++;
            if (bus.out_valid !== exp_valid || bus.data_out !== exp_data)
                $display("FAIL b2b edge %0d: out_valid=%b data_out=%0d, want %b/%0d",
                         i + 1, bus.out_valid, bus.data_out, exp_valid, exp_data);
            else passes++;
        end
        seq_ok = (got.size() == 16);
        for (int i = 0; i < got.size() && i < 16; i++)
            if (got[i] !== 8'(i + 1)) seq_ok = 1'b0;
        checks++;
        if (!seq_ok)
            $display("FAIL b2b_seq: got %0d words %p, want 1..16", got.size(), got);
        else passes++;
        checks++;
        if (max_run != 16)
            $display("FAIL b2b_run: longest out_valid run %0d, want 16", max_run);
        else passes++;
    endtask

    task automatic test_random();
        logic v;
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 300; i++) begin
            // Mix dense bursts with sparse stretches.
            if ((i / 50) % 2 == 0) v = ($urandom_range(0, 7) != 0);
            else v = ($urandom_range(0, 2) == 0);
            d = 8'($urandom_range(0, 255));
            drive_edge(v, d);
            checks++;
            if (bus.out_valid !== exp_valid || bus.data_out !== exp_data)
                $display("FAIL random edge %0d: out_valid=%b data_out=%0d, want %b/%0d",
                         i, bus.out_valid, bus.data_out, exp_valid, exp_data);
            else passes++;
        end
        for (int i = 0; i < 6; i++) begin
            drive_edge(1'b0, '0);
            checks++;
            if (bus.out_valid !== exp_valid || bus.data_out !== exp_data)
                $display("FAIL random_tail edge %0d: out_valid=%b data_out=%0d, want %b/%0d",
                         i, bus.out_valid, bus.data_out, exp_valid, exp_data);
            else passes++;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.valid = 1'b0;
        bus.data_in = '0;
        model_reset();
        test_reset();
        test_first_block();
        test_gap();
        test_reset_mid();
        test_after_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
